// File: rtl/hit_scheduler.sv
// hit_scheduler: frame-rate damage controller between the hit detector and
// the blood counter. Samples per-frame hit flags, masks them with per-target
// cooldown, and serves the two targets round-robin on one shared decrement bus.
// Optional combo bonus logic is built when HIT_SCHEDULER_COMBO_EN is defined.
module hit_scheduler #(
  parameter int HIT_PUNCH    = 15,
  parameter int HIT_KICK     = 10,
  parameter int HIT_INTERVAL = 5
`ifdef HIT_SCHEDULER_COMBO_EN
  , parameter int COMBO_WINDOW = 3
`endif
) (
  input  logic        clk,
  input  logic        reset_game,
  input  logic        keep,
  input  logic        fresh,
  input  logic [3:0]  hit,
  output logic [15:0] blood_dec,
  output logic        dec_valid,
  output logic [1:0]  grant,
  output logic        cool_a,
  output logic        cool_b,
  output logic [1:0]  combo_a,
  output logic [1:0]  combo_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t      state, state_n;
  logic        fresh_d;
  logic        tick;
  logic        req_a, req_b, req_a_n, req_b_n;
  logic [3:0]  hit_lat, hit_lat_n;
  logic        rr, rr_n;
  logic [3:0]  cnt_a, cnt_b, cnt_a_n, cnt_b_n;
  logic [15:0] blood_dec_n;
  logic        dec_valid_n;
  logic [1:0]  grant_n;
  logic        serve_a;
  logic [2:0]  bonus_a, bonus_b;

  // Granted damage with saturation at one byte
  function automatic logic [7:0] damage(input logic punch, input logic kick,
                                        input logic [2:0] bonus);
    logic [9:0] sum;
    sum = 10'd0;
    if (punch) sum = sum + 10'(HIT_PUNCH);
    if (kick)  sum = sum + 10'(HIT_KICK);
    sum = sum + {7'd0, bonus};
    damage = (sum > 10'd255) ? 8'hFF : sum[7:0];
  endfunction

  assign tick   = fresh & ~fresh_d;
  assign cool_a = (cnt_a != 4'd0);
  assign cool_b = (cnt_b != 4'd0);

`ifdef HIT_SCHEDULER_COMBO_EN
  logic [3:0] win_a, win_b, win_a_n, win_b_n;
  logic [1:0] lvl_a, lvl_b, lvl_a_n, lvl_b_n;
  logic [1:0] lvl_a_up, lvl_b_up;

  assign lvl_a_up = (win_a != 4'd0) ? ((lvl_a == 2'd3) ? 2'd3 : lvl_a + 2'd1) : 2'd0;
  assign lvl_b_up = (win_b != 4'd0) ? ((lvl_b == 2'd3) ? 2'd3 : lvl_b + 2'd1) : 2'd0;
  assign bonus_a  = {lvl_a_up, 1'b0};
  assign bonus_b  = {lvl_b_up, 1'b0};
  assign combo_a  = lvl_a;
  assign combo_b  = lvl_b;
`else
  assign bonus_a  = 3'd0;
  assign bonus_b  = 3'd0;
  assign combo_a  = 2'd0;
  assign combo_b  = 2'd0;
`endif

  // Next-state and next-register values for the whole scheduler
  always_comb begin
    state_n     = state;
    req_a_n     = req_a;
    req_b_n     = req_b;
    hit_lat_n   = hit_lat;
    rr_n        = rr;
    cnt_a_n     = cnt_a;
    cnt_b_n     = cnt_b;
    blood_dec_n = 16'd0;
    dec_valid_n = 1'b0;
    grant_n     = 2'b00;
    serve_a     = 1'b0;
`ifdef HIT_SCHEDULER_COMBO_EN
    win_a_n     = win_a;
    win_b_n     = win_b;
    lvl_a_n     = lvl_a;
    lvl_b_n     = lvl_b;
`endif
    if (keep) begin
      state_n = IDLE;
      req_a_n = 1'b0;
      req_b_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            if (cnt_a != 4'd0) cnt_a_n = cnt_a - 4'd1;
            if (cnt_b != 4'd0) cnt_b_n = cnt_b - 4'd1;
            req_a_n   = (|hit[3:2]) & (cnt_a == 4'd0);
            req_b_n   = (|hit[1:0]) & (cnt_b == 4'd0);
            hit_lat_n = hit;
`ifdef HIT_SCHEDULER_COMBO_EN
            if (cnt_a == 4'd1)       win_a_n = 4'(COMBO_WINDOW);
            else if (win_a != 4'd0)  win_a_n = win_a - 4'd1;
            if (cnt_b == 4'd1)       win_b_n = 4'(COMBO_WINDOW);
            else if (win_b != 4'd0)  win_b_n = win_b - 4'd1;
`endif
            if (req_a_n || req_b_n) state_n = ARB;
          end
        end
        ARB: begin
          if (req_a || req_b) begin
            serve_a = req_a & (~req_b | ~rr);
            if (req_a && req_b) rr_n = ~rr;
            if (serve_a) begin
              req_a_n     = 1'b0;
              blood_dec_n = {damage(hit_lat[3], hit_lat[2], bonus_a), 8'd0};
              grant_n     = 2'b10;
              cnt_a_n     = 4'(HIT_INTERVAL);
`ifdef HIT_SCHEDULER_COMBO_EN
              lvl_a_n     = lvl_a_up;
`endif
            end else begin
              req_b_n     = 1'b0;
              blood_dec_n = {8'd0, damage(hit_lat[1], hit_lat[0], bonus_b)};
              grant_n     = 2'b01;
              cnt_b_n     = 4'(HIT_INTERVAL);
`ifdef HIT_SCHEDULER_COMBO_EN
              lvl_b_n     = lvl_b_up;
`endif
            end
            dec_valid_n = 1'b1;
            state_n     = APPLY;
          end else begin
            state_n = IDLE;
          end
        end
        APPLY: begin
          state_n = (req_a || req_b) ? ARB : IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_game) begin
    if (!reset_game) state <= IDLE;
    else             state <= state_n;
  end

  // Datapath registers: frame edge detect, requests, cooldowns, registered outputs
  always_ff @(posedge clk or negedge reset_game) begin
    if (!reset_game) begin
      fresh_d   <= 1'b0;
      req_a     <= 1'b0;
      req_b     <= 1'b0;
      hit_lat   <= 4'd0;
      rr        <= 1'b0;
      cnt_a     <= 4'd0;
      cnt_b     <= 4'd0;
      blood_dec <= 16'd0;
      dec_valid <= 1'b0;
      grant     <= 2'b00;
    end else begin
      fresh_d   <= fresh;
      req_a     <= req_a_n;
      req_b     <= req_b_n;
      hit_lat   <= hit_lat_n;
      rr        <= rr_n;
      cnt_a     <= cnt_a_n;
      cnt_b     <= cnt_b_n;
      blood_dec <= blood_dec_n;
      dec_valid <= dec_valid_n;
      grant     <= grant_n;
    end
  end

`ifdef HIT_SCHEDULER_COMBO_EN
  // Combo window counters and combo levels
  always_ff @(posedge clk or negedge reset_game) begin
    if (!reset_game) begin
      win_a <= 4'd0;
      win_b <= 4'd0;
      lvl_a <= 2'd0;
      lvl_b <= 2'd0;
    end else begin
      win_a <= win_a_n;
      win_b <= win_b_n;
      lvl_a <= lvl_a_n;
      lvl_b <= lvl_b_n;
    end
  end
`endif

endmodule

// File: tb/tb_hit_scheduler.sv
// tb_hit_scheduler: scoreboard bench for hit_scheduler. Frames push expected
// pulses (value and cycle) into a queue; a negedge monitor pops and compares.
module tb_hit_scheduler;

  logic        clk;
  logic        reset_game;
  logic        keep;
  logic        fresh;
  logic [3:0]  hit;
  logic [15:0] blood_dec;
  logic        dec_valid;
  logic [1:0]  grant;
  logic        cool_a, cool_b;
  logic [1:0]  combo_a, combo_b;

  typedef struct {
    logic [15:0] dec;
    logic [1:0]  grant;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  hit_scheduler dut (
    .clk        (clk),
    .reset_game (reset_game),
    .keep       (keep),
    .fresh      (fresh),
    .hit        (hit),
    .blood_dec  (blood_dec),
    .dec_valid  (dec_valid),
    .grant      (grant),
    .cool_a     (cool_a),
    .cool_b     (cool_b),
    .combo_a    (combo_a),
    .combo_b    (combo_b)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time pulses relative to the frame start
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every presented pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (reset_game && dec_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pulse: got blood_dec=%0h want none (cycle %0d)",
                 blood_dec, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("blood_dec", 32'(blood_dec), 32'(e.dec));
        checkOutput("grant", 32'(grant), 32'(e.grant));
        checkOutput("pulse_cycle", 32'(cyc), 32'(e.at));
        checkOutput("cool_granted", 32'(e.grant[1] ? cool_a : cool_b), 32'd1);
      end
    end
  end

  function automatic exp_t mk(input logic [15:0] d, input int at);
    exp_t e;
    e.dec   = d;
    e.grant = (d[15:8] != 8'd0) ? 2'b10 : 2'b01;
    e.at    = at;
    return e;
  endfunction

  // One frame: fresh high 4 cycles, low 4; n expected pulses at +2 and +4
  task automatic applyStimulus(input logic [3:0] h, input logic [15:0] d0,
                               input logic [15:0] d1, input int n);
    int start;
    @(negedge clk);
    hit   = h;
    fresh = 1'b1;
    start = cyc;
    if (n >= 1) sb.push_back(mk(d0, start + 2));
    if (n >= 2) sb.push_back(mk(d1, start + 4));
    repeat (4) @(negedge clk);
    fresh = 1'b0;
    hit   = 4'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic idleFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'd0, 16'd0, 16'd0, 0);
  endtask

  // Main directed sequence
  initial begin
    reset_game = 1'b0;
    keep       = 1'b0;
    fresh      = 1'b0;
    hit        = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_dec_valid", 32'(dec_valid), 32'd0);
    checkOutput("rst_blood_dec", 32'(blood_dec), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_cool_a", 32'(cool_a), 32'd0);
    checkOutput("rst_cool_b", 32'(cool_b), 32'd0);
    reset_game = 1'b1;
    repeat (2) @(negedge clk);

    // Single punch on A
    applyStimulus(4'b1000, 16'h0F00, 16'd0, 1);
    idleFrames(5);
    checkOutput("cool_a_expired", 32'(cool_a), 32'd0);

    // Held punch+kick on A for 7 frames: pulses only in frames 1 and 7
    for (int f = 1; f <= 7; f++) begin
      checkOutput("cool_a_frame", 32'(cool_a), (f >= 2 && f <= 6) ? 32'd1 : 32'd0);
      if (f == 1 || f == 7) applyStimulus(4'b1100, 16'h1900, 16'd0, 1);
      else                  applyStimulus(4'b1100, 16'd0, 16'd0, 0);
    end
    idleFrames(5);

    // Both targets in one frame, serving order alternates
    applyStimulus(4'b1111, 16'h1900, 16'h0019, 2);
    idleFrames(6);
    applyStimulus(4'b1111, 16'h0019, 16'h1900, 2);
    idleFrames(6);

    // keep raised while ARB holds both requests: no pulse, pointer held
    @(negedge clk);
    hit   = 4'b1111;
    fresh = 1'b1;
    @(posedge clk);
    #1 keep = 1'b1;
    repeat (4) @(negedge clk);
    fresh = 1'b0;
    hit   = 4'd0;
    repeat (4) @(negedge clk);
    checkOutput("keep_arb_cool_a", 32'(cool_a), 32'd0);
    checkOutput("keep_arb_cool_b", 32'(cool_b), 32'd0);
    keep = 1'b0;
    applyStimulus(4'b1111, 16'h1900, 16'h0019, 2);

    // No cooldown decrement while frozen
    keep = 1'b1;
    idleFrames(6);
    checkOutput("keep_hold_cool_a", 32'(cool_a), 32'd1);
    checkOutput("keep_hold_cool_b", 32'(cool_b), 32'd1);
    keep = 1'b0;
    idleFrames(4);
    checkOutput("resume_cool_a", 32'(cool_a), 32'd1);
    idleFrames(1);
    checkOutput("resume_cool_a_done", 32'(cool_a), 32'd0);
    checkOutput("resume_cool_b_done", 32'(cool_b), 32'd0);

    // Asynchronous reset in the middle of APPLY
    @(negedge clk);
    hit   = 4'b1000;
    fresh = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("apply_before_reset", 32'(dec_valid), 32'd1);
    reset_game = 1'b0;
    #1;
    checkOutput("async_rst_dec_valid", 32'(dec_valid), 32'd0);
    checkOutput("async_rst_blood_dec", 32'(blood_dec), 32'd0);
    checkOutput("async_rst_grant", 32'(grant), 32'd0);
    checkOutput("async_rst_cool_a", 32'(cool_a), 32'd0);
    @(negedge clk);
    fresh = 1'b0;
    hit   = 4'd0;
    reset_game = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(4'b0001, 16'h000A, 16'd0, 1);

`ifdef HIT_SCHEDULER_COMBO_EN
    // Combo: punch on B every 6 frames ramps bonus by 2 up to level 3
    @(negedge clk);
    reset_game = 1'b0;
    @(negedge clk);
    reset_game = 1'b1;
    applyStimulus(4'b0010, 16'h000F, 16'd0, 1);
    idleFrames(5);
    applyStimulus(4'b0010, 16'h0011, 16'd0, 1);
    idleFrames(5);
    applyStimulus(4'b0010, 16'h0013, 16'd0, 1);
    idleFrames(5);
    applyStimulus(4'b0010, 16'h0015, 16'd0, 1);
    idleFrames(5);
    applyStimulus(4'b0010, 16'h0015, 16'd0, 1);
    checkOutput("combo_b_level", 32'(combo_b), 32'd3);
    checkOutput("combo_a_level", 32'(combo_a), 32'd0);
`else
    checkOutput("combo_a_tied", 32'(combo_a), 32'd0);
    checkOutput("combo_b_tied", 32'(combo_b), 32'd0);
`endif

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
